// File: rtl/alu_share_arb.sv
// alu_share_arb: two-requester round-robin arbiter and sequencer for one
// shared ALU. Port 0 is the execute stage, port 1 the branch/address helper.
// The winning request's operands are muxed onto the ALU combinationally.
// The ALU result is registered into a single response slot that has
// back-pressure. The slot can retire and reload on the same edge, so
// sustained throughput is one operation per cycle.
// Optional feature macro: ARB_STATS_EN adds the saturating grant/contention
// counters stat_g0, stat_g1, stat_conf and the synchronous clear clr_stats.
module alu_share_arb #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [3:0]        ctrl0,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] b0,
    input  logic [4:0]        sh0,
    output logic              gnt0,
    input  logic              req1,
    input  logic [3:0]        ctrl1,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] b1,
    input  logic [4:0]        sh1,
    output logic              gnt1,
    output logic [3:0]        alu_ctrl,
    output logic [DATA_W-1:0] alu_src1,
    output logic [DATA_W-1:0] alu_src2,
    output logic [4:0]        alu_shamt,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    output logic              resp_valid,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_zero,
    input  logic              resp_ready
`ifdef ARB_STATS_EN
    ,
    input  logic              clr_stats,
    output logic [CNT_W-1:0]  stat_g0,
    output logic [CNT_W-1:0]  stat_g1,
    output logic [CNT_W-1:0]  stat_conf
`endif
);

    logic              last_q, last_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_id_q, resp_id_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              resp_zero_q, resp_zero_d;

    logic free;
    logic winner;
    logic grant;

    // Arbitration: slot availability, round-robin winner and grant strobes.
    always_comb begin
        free   = !resp_valid_q || resp_ready;
        winner = 1'b0;
        if (req0 && req1) begin
            winner = ~last_q;
        end else if (req1) begin
            winner = 1'b1;
        end
        grant = (req0 || req1) && free;
        gnt0  = grant && !winner;
        gnt1  = grant && winner;
    end

    // Drive the ALU from the granted requester; zeros when nothing is granted.
    always_comb begin
        alu_ctrl  = 4'd0;
        alu_src1  = '0;
        alu_src2  = '0;
        alu_shamt = 5'd0;
        if (gnt0) begin
            alu_ctrl  = ctrl0;
            alu_src1  = a0;
            alu_src2  = b0;
            alu_shamt = sh0;
        end else if (gnt1) begin
            alu_ctrl  = ctrl1;
            alu_src1  = a1;
            alu_src2  = b1;
            alu_shamt = sh1;
        end
    end

    // Next state of the response slot and the priority pointer.
    always_comb begin
        last_d       = last_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        resp_zero_d  = resp_zero_q;
        if (grant) begin
            resp_valid_d = 1'b1;
            resp_id_d    = winner;
            resp_data_d  = alu_out;
            resp_zero_d  = alu_zero;
            last_d       = winner;
        end else if (resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    // State registers; reset drops any in-flight result and favours port 0 next.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q       <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_data_q  <= '0;
            resp_zero_q  <= 1'b0;
        end else begin
            last_q       <= last_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
            resp_zero_q  <= resp_zero_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
    assign resp_zero  = resp_zero_q;

`ifdef ARB_STATS_EN
    logic [CNT_W-1:0] g0_cnt_q, g1_cnt_q, conf_cnt_q;
    logic [CNT_W-1:0] g0_cnt_d, g1_cnt_d, conf_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    // Counter next state: clear wins over any increment in the same cycle.
    always_comb begin
        g0_cnt_d   = g0_cnt_q;
        g1_cnt_d   = g1_cnt_q;
        conf_cnt_d = conf_cnt_q;
        if (clr_stats) begin
            g0_cnt_d   = '0;
            g1_cnt_d   = '0;
            conf_cnt_d = '0;
        end else begin
            if (gnt0) g0_cnt_d = sat_inc(g0_cnt_q);
            if (gnt1) g1_cnt_d = sat_inc(g1_cnt_q);
            if (req0 && req1 && free) conf_cnt_d = sat_inc(conf_cnt_q);
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            g0_cnt_q   <= '0;
            g1_cnt_q   <= '0;
            conf_cnt_q <= '0;
        end else begin
            g0_cnt_q   <= g0_cnt_d;
            g1_cnt_q   <= g1_cnt_d;
            conf_cnt_q <= conf_cnt_d;
        end
    end

    assign stat_g0   = g0_cnt_q;
    assign stat_g1   = g1_cnt_q;
    assign stat_conf = conf_cnt_q;
`endif

endmodule
